fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
- Sits between the i2s receiver and the FFT core.
- Collects per-sample audio words into a two-bank (ping-pong) sample RAM by generating write address, data and bank.
- When a bank holds N samples, it hands that bank to the FFT with a start/done handshake, then swaps banks.
- Detects and flags overrun when the FFT is too slow, and counts frames issued.

Parameters:
WIDTH, 24, sample word width (matches i2s left/right)
N, 32, samples per frame; power of two, >= 4
LOG2N, 5, log2(N); width of address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe, new sample pair present
sample_left  in  WIDTH  signed left sample
sample_right  in  WIDTH  signed right sample (used only with MONO_MIX_EN)
fft_done  in  1  one-cycle pulse, FFT finished reading fft_bank
clear_overrun  in  1  synchronous clear of overrun flag
wr_en  out  1  RAM write enable
wr_bank  out  1  bank being written
wr_addr  out  LOG2N  RAM write address
wr_data  out  WIDTH  RAM write data
fft_start  out  1  one-cycle pulse, frame ready in fft_bank
fft_bank  out  1  bank owned by FFT; stable from fft_start until fft_done
fft_busy  out  1  high from fft_start cycle through fft_done cycle
overrun  out  1  sticky, samples dropped
frame_count  out  16  frames issued, wraps at 65535 -> 0

Behaviour:
- Reset (reset low, async): all outputs 0; writer FSM = FILLING; FFT FSM = IDLE; internal address 0; no pending bank.
- Writer FSM: FILLING and STALLED.
  - FILLING, sample_valid high at edge t: in cycle t+1, wr_en = 1, wr_addr = current address, wr_bank = current bank, wr_data = sample. Address then increments.
  - Write of address N-1 (bank complete): address wraps to 0 and the bank becomes pending.
  - If the FFT is IDLE, or fft_done is high in the same cycle as completion, the pending bank is issued: fft_start pulses in cycle t+2 (after the last write commits), fft_bank = completed bank, frame_count increments. The writer toggles bank and stays FILLING.
  - If the FFT is BUSY at completion: writer enters STALLED. The next bank is not writable.
- STALLED:
  - Every sample_valid is dropped (wr_en stays 0) and sets overrun.
  - On fft_done: the pending bank is issued with fft_start the following cycle. The writer toggles bank, address is 0, and it returns to FILLING.
  - A sample_valid in the same cycle as fft_done is dropped and sets overrun. Accepting resumes the next cycle.
- FFT FSM:
  - IDLE -> BUSY on fft_start.
  - BUSY -> IDLE on fft_done.
  - fft_done while IDLE is ignored.
- wr_en is a single-cycle pulse per accepted sample. Back-to-back sample_valid on consecutive cycles is supported.
- overrun: set has priority over clear_overrun in the same cycle; cleared only by clear_overrun or reset.
- Reset mid-frame: partial bank discarded; the next frame starts at bank 0, address 0.

Optional Feature:
MONO_MIX_EN
- Defined: wr_data = (sign-extended sample_left + sample_right) arithmetically shifted right by 1, using a WIDTH+1 intermediate. Truncates toward negative infinity; no overflow possible.
- Undefined: wr_data = sample_left; sample_right is unused. Latency is identical in both builds.

Test Plan:
- Reset low for 10 clk, then N=32 sample_valid strobes every 4 clk with left = index -> wr_addr 0..31 on bank 0, wr_data = index, fft_start one pulse 2 cycles after the 32nd strobe, fft_bank = 0, frame_count = 1.
- fft_done 50 clk after start, then 32 more samples -> second frame written to bank 1, fft_start with fft_bank = 1, frame_count = 2, overrun = 0.
- Withhold fft_done across completion of a second bank, feed 3 extra samples -> no wr_en for the 3 samples, overrun = 1. Pulse fft_done -> fft_start next cycle with the pending bank, writer resumes at address 0; clear_overrun -> overrun = 0.
- fft_done and the 32nd sample_valid in the same cycle -> no stall, fft_start 2 cycles later, no overrun.
- MONO_MIX_EN: left = 0x7FFFFF, right = 0x7FFFFF -> 0x7FFFFF; left = 0x800000, right = 0x000001 -> 0xC00000; left = -1, right = 0 -> 0xFFFFFF.
- Assert reset at sample 17 of a frame -> all outputs 0 immediately. After release, the first write is bank 0, address 0, and frame_count = 0.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame scheduler between the i2s receiver and the FFT core.
// Optional build macro MONO_MIX_EN: the RAM word is (left + right) / 2 instead of left.
module fft_frame_scheduler #(
    parameter int WIDTH = 24,
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_left,
    input  logic [WIDTH-1:0] sample_right,
    input  logic             fft_done,
    input  logic             clear_overrun,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             fft_start,
    output logic             fft_bank,
    output logic             fft_busy,
    output logic             overrun,
    output logic [15:0]      frame_count
);

    typedef enum logic {FILLING, STALLED} wr_state_t;
    typedef enum logic {IDLE, BUSY} fft_state_t;

    wr_state_t        wr_state, wr_state_nxt;
    fft_state_t       fft_state, fft_state_nxt;
    logic [LOG2N-1:0] addr;
    logic             cur_bank;
    logic             issue_q;
    logic             issue_bank_q;
    logic [WIDTH-1:0] mix_data;

    logic accept, last, drop, fft_free, issue_now;

`ifdef MONO_MIX_EN
    logic [WIDTH:0] mix_sum;
    assign mix_sum  = {sample_left[WIDTH-1], sample_left} + {sample_right[WIDTH-1], sample_right};
    assign mix_data = mix_sum[WIDTH:1];
`else
    logic unused_right;
    assign unused_right = ^sample_right;
    assign mix_data     = sample_left;
`endif

    always_comb begin
        accept        = (wr_state == FILLING) && sample_valid;
        last          = accept && (addr == LOG2N'(N - 1));
        drop          = (wr_state == STALLED) && sample_valid;
        fft_free      = (fft_state == IDLE) || fft_done;
        // A completed bank goes out as soon as the FFT is free; a stalled bank waits for done.
        issue_now     = (last && fft_free) || ((wr_state == STALLED) && fft_done);
        wr_state_nxt  = wr_state;
        fft_state_nxt = fft_state;
        case (wr_state)
            FILLING: if (last && !fft_free) wr_state_nxt = STALLED;
            STALLED: if (fft_done)          wr_state_nxt = FILLING;
            default: wr_state_nxt = FILLING;
        endcase
        case (fft_state)
            IDLE:    if (issue_q)  fft_state_nxt = BUSY;
            BUSY:    if (fft_done) fft_state_nxt = IDLE;
            default: fft_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state  <= FILLING;
            fft_state <= IDLE;
        end else begin
            wr_state  <= wr_state_nxt;
            fft_state <= fft_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr         <= '0;
            cur_bank     <= 1'b0;
            issue_q      <= 1'b0;
            issue_bank_q <= 1'b0;
            wr_en        <= 1'b0;
            wr_bank      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            fft_start    <= 1'b0;
            fft_bank     <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= '0;
        end else begin
            wr_en     <= accept;
            issue_q   <= issue_now;
            fft_start <= issue_q;
            if (accept) begin
                addr    <= addr + 1'b1;
                wr_addr <= addr;
                wr_bank <= cur_bank;
                wr_data <= mix_data;
            end
            if (issue_now) begin
                issue_bank_q <= cur_bank;
                cur_bank     <= ~cur_bank;
            end
            if (issue_q) begin
                fft_bank    <= issue_bank_q;
                frame_count <= frame_count + 16'd1;
            end
            if (drop)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

    assign fft_busy = (fft_state == BUSY);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed self-checking bench for fft_frame_scheduler (N = 32, WIDTH = 24).
module tb_fft_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_left = '0;
    logic [23:0] sample_right = '0;
    logic        fft_done = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        wr_en, wr_bank, fft_start, fft_bank, fft_busy, overrun;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_err = 0;

    fft_frame_scheduler #(.WIDTH(24), .N(32), .LOG2N(5)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .sample_left(sample_left), .sample_right(sample_right),
        .fft_done(fft_done), .clear_overrun(clear_overrun),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .fft_start(fft_start), .fft_bank(fft_bank), .fft_busy(fft_busy),
        .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_word(input logic [23:0] l, input logic [23:0] r);
`ifdef MONO_MIX_EN
        int s;
        s = ($signed(l) + $signed(r)) >>> 1;
        return s[23:0];
`else
        return l;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r, input logic en,
                        input logic [4:0] a, input logic b);
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        tick();
        sample_valid = 1'b0;
        chk("wr_en", {31'd0, wr_en}, {31'd0, en});
        if (en) begin
            chk("wr_addr", {27'd0, wr_addr}, {27'd0, a});
            chk("wr_bank", {31'd0, wr_bank}, {31'd0, b});
            chk("wr_data", {8'd0, wr_data}, {8'd0, exp_word(l, r)});
        end
    endtask

    task automatic expect_start(input logic b, input logic [15:0] fc);
        chk("start_early", {31'd0, fft_start}, 32'd0);
        tick();
        chk("fft_start", {31'd0, fft_start}, 32'd1);
        chk("fft_bank", {31'd0, fft_bank}, {31'd0, b});
        chk("frame_count", {16'd0, frame_count}, {16'd0, fc});
        chk("fft_busy", {31'd0, fft_busy}, 32'd1);
        tick();
        chk("start_pulse", {31'd0, fft_start}, 32'd0);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out"}, {wr_en, wr_bank, fft_start, fft_bank, fft_busy, overrun, wr_addr, 16'd0},
            32'd0);
        chk({tag, "_data"}, {8'd0, wr_data}, 32'd0);
        chk({tag, "_fc"}, {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        idle(10);
        check_all_zero("reset");
        reset = 1'b1;
        idle(2);

        // frame 0 on bank 0, a strobe every 4 clocks
        for (int i = 0; i < 32; i++) begin
            send(24'(i), 24'd0, 1'b1, 5'(i), 1'b0);
            if (i < 31) idle(3);
        end
        expect_start(1'b0, 16'd1);

        // done 50 clocks after start, then frame 1 on bank 1
        idle(47);
        pulse_done();
        chk("busy_after_done", {31'd0, fft_busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            send(24'(100 + i), 24'd5, 1'b1, 5'(i), 1'b1);
            if (i < 31) idle(3);
        end
        expect_start(1'b1, 16'd2);
        chk("overrun_f1", {31'd0, overrun}, 32'd0);

        // frame 2 completes while the FFT still owns bank 1 -> stall
        for (int i = 0; i < 32; i++) begin
            send(24'(200 + i), 24'd0, 1'b1, 5'(i), 1'b0);
            if (i < 31) idle(3);
        end
        idle(1);
        chk("no_start_stalled", {31'd0, fft_start}, 32'd0);
        chk("busy_stalled", {31'd0, fft_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send(24'h00ABCD, 24'd0, 1'b0, 5'd0, 1'b0);
            chk("overrun_set", {31'd0, overrun}, 32'd1);
            idle(2);
        end
        // done together with a strobe: the strobe is dropped
        fft_done = 1'b1;
        send(24'h00BEEF, 24'd0, 1'b0, 5'd0, 1'b0);
        fft_done = 1'b0;
        chk("busy_released", {31'd0, fft_busy}, 32'd0);
        expect_start(1'b0, 16'd3);
        send(24'h000300, 24'd0, 1'b1, 5'd0, 1'b1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_clear", {31'd0, overrun}, 32'd0);

        // finish bank 1 with done in the same cycle as the 32nd strobe
        for (int i = 1; i < 32; i++) begin
            if (i == 31) fft_done = 1'b1;
            send(24'(300 + i), 24'd0, 1'b1, 5'(i), 1'b1);
            fft_done = 1'b0;
            if (i < 31) idle(3);
        end
        chk("overrun_same_cycle", {31'd0, overrun}, 32'd0);
        expect_start(1'b1, 16'd4);

        // back-to-back frame on bank 0 with the FFT idle
        pulse_done();
        for (int i = 0; i < 32; i++)
            send(24'(400 + i), 24'h000011, 1'b1, 5'(i), 1'b0);
        expect_start(1'b0, 16'd5);

        // bank 1: mixing corner vectors, then reset at sample 17
        send(24'h7FFFFF, 24'h7FFFFF, 1'b1, 5'd0, 1'b1);
        send(24'h800000, 24'h000001, 1'b1, 5'd1, 1'b1);
        send(24'hFFFFFF, 24'h000000, 1'b1, 5'd2, 1'b1);
        for (int i = 3; i < 17; i++) begin
            send(24'(500 + i), 24'd0, 1'b1, 5'(i), 1'b1);
            idle(1);
        end
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        idle(3);
        reset = 1'b1;
        idle(1);
        send(24'h000777, 24'd0, 1'b1, 5'd0, 1'b0);
        chk("fc_after_reset", {16'd0, frame_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
